// File: rtl/conv_window_mac_pkg.sv
// Shared helpers for conv_window_mac: width derivation, coefficient address type, clip function.
package conv_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_K      = 3;
    localparam int DEF_ROWS   = 3;
    localparam int MAX_W      = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Sum of ROWS*K products never overflows this width.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + 1 + clog2(taps);
    endfunction

    localparam int ACC_W = acc_width(DEF_DATA_W, DEF_COEF_W, DEF_ROWS * DEF_K);

    typedef logic [clog2(DEF_ROWS * DEF_K)-1:0] coef_addr_t;

    function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] v,
                                                          input int out_w);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_window_mac_row.sv
// One window row: K registered products and their combinational partial sum.
module conv_row_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int K      = 3,
    parameter int ACC_W  = 21
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [K*DATA_W-1:0]      data_i,
    input  logic [K*COEF_W-1:0]      coef_i,
    output logic signed [ACC_W-1:0]  psum_o
);
    localparam int PROD_W = DATA_W + COEF_W + 1;

    logic signed [PROD_W-1:0] prod_q [K];
    logic signed [PROD_W-1:0] prod_d [K];

    // Pixels are unsigned: prepend a zero so the signed multiply keeps their magnitude.
    always_comb begin
        for (int c = 0; c < K; c++) begin
            prod_d[c] = PROD_W'($signed({1'b0, data_i[c*DATA_W +: DATA_W]}))
                      * PROD_W'($signed(coef_i[c*COEF_W +: COEF_W]));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < K; c++) prod_q[c] <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
        end
    end

    always_comb begin
        psum_o = '0;
        for (int c = 0; c < K; c++) psum_o = psum_o + ACC_W'(prod_q[c]);
    end

endmodule

// File: rtl/conv_window_mac.sv
// Streaming K x ROWS convolution MAC with valid/ready flow control and window flush.
// Define CONV_WINDOW_SAT_EN to clip results to OUT_W instead of truncating them.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int K         = 3,
    parameter int ROWS      = 3,
    parameter int OUT_SHIFT = 4,
    parameter int OUT_W     = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_W-1:0]     in_data,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [clog2(ROWS*K)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_sat
);
    localparam int NT     = ROWS * K;
    localparam int FILL_W = clog2(K + 1);
    localparam int ACC_LW = acc_width(DATA_W, COEF_W, NT);

    // Handshake: a column transfers when in_valid && in_ready, a result when out_valid && out_ready;
    // every stage advances together whenever the output register is empty or being drained.
    logic                     en, accept, launch;
    logic [K*DATA_W-1:0]      win_q [ROWS];
    logic [K*DATA_W-1:0]      win_d [ROWS];
    logic [COEF_W-1:0]        coef_q [NT];
    logic [K*COEF_W-1:0]      coef_row [ROWS];
    logic signed [ACC_LW-1:0] psum [ROWS];
    logic signed [ACC_LW-1:0] total;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic                     tok0_q, tok1_q, out_valid_q, out_sat_q, out_sat_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & en;
    assign launch   = accept & ~flush & (fill_q >= FILL_W'(K - 1));

    // A flush during a stall only resets the fill count: the window may still feed a pending
    // token, and K fresh columns overwrite it before the next launch anyway.
    always_comb begin
        fill_d = fill_q;
        if (flush) fill_d = accept ? FILL_W'(1) : '0;
        else if (accept && fill_q != FILL_W'(K)) fill_d = fill_q + FILL_W'(1);
        for (int r = 0; r < ROWS; r++) begin
            win_d[r] = win_q[r];
            if (flush && en)
                win_d[r] = accept ? {in_data[r*DATA_W +: DATA_W], {((K-1)*DATA_W){1'b0}}} : '0;
            else if (accept)
                win_d[r] = {in_data[r*DATA_W +: DATA_W], win_q[r][K*DATA_W-1:DATA_W]};
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            coef_row[r] = '0;
            for (int c = 0; c < K; c++) coef_row[r][c*COEF_W +: COEF_W] = coef_q[r*K + c];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int r = 0; r < ROWS; r++) win_q[r] <= '0;
            for (int i = 0; i < NT; i++) coef_q[i] <= '0;
            fill_q      <= '0;
            tok0_q      <= 1'b0;
            tok1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            if (coef_we && int'(coef_addr) < NT) coef_q[coef_addr] <= coef_data;
            if (en) begin
                tok0_q      <= launch;
                tok1_q      <= tok0_q;
                out_valid_q <= tok1_q;
                out_data_q  <= out_data_d;
                out_sat_q   <= out_sat_d;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        conv_row_mac #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .K      (K),
            .ACC_W  (ACC_LW)
        ) u_row (
            .clk_i  (CLK),
            .rst_i  (RESET),
            .en_i   (en),
            .data_i (win_q[r]),
            .coef_i (coef_row[r]),
            .psum_o (psum[r])
        );
    end

`ifdef CONV_WINDOW_SAT_EN
    logic signed [MAX_W-1:0] ext, clipped;
`endif

    always_comb begin
        total = '0;
        for (int r = 0; r < ROWS; r++) total = total + psum[r];
`ifdef CONV_WINDOW_SAT_EN
        ext        = MAX_W'(total >>> OUT_SHIFT);
        clipped    = saturate(ext, OUT_W);
        out_data_d = OUT_W'(clipped);
        out_sat_d  = (clipped != ext);
`else
        out_data_d = OUT_W'(total >>> OUT_SHIFT);
        out_sat_d  = 1'b0;
`endif
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed plus randomized bench for conv_window_mac against a queue-based window model.
module tb_conv_window_mac;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int K = 3;
  localparam int ROWS = 3;
  localparam int OW = 16;
  localparam int NT = 9;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic coef_we = 1'b0;
  logic out_ready = 1'b1;
  logic [ROWS*DW-1:0] in_data = '0;
  logic [3:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic in_ready, out_valid, out_sat;
  logic in_ready_s, out_valid_s, out_sat_s;
  logic [OW-1:0] out_data, out_data_s;

  logic signed [CW-1:0] m_coef [NT];
  logic [ROWS*DW-1:0] m_win [$];
  logic [2*OW+1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic stall_prev = 1'b0;
  logic [OW-1:0] stall_data = '0;

  // clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  conv_window_mac dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  conv_window_mac #(.OUT_SHIFT(0)) dut_s (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_sat(out_sat_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard model: floor-shift the exact window sum, then clip or wrap to OW bits
  function automatic logic [OW:0] model_result(input longint sum, input int shift);
    longint r;
    logic sat;
    r = sum >>> shift;
    sat = 1'b0;
`ifdef CONV_WINDOW_SAT_EN
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
`endif
    return {sat, r[OW-1:0]};
  endfunction

  task automatic model_step(input logic acc, input logic [ROWS*DW-1:0] d, input logic fl);
    longint sum;
    logic [OW:0] a, b;
    if (fl) m_win.delete();
    if (acc) begin
      m_win.push_back(d);
      if (m_win.size() > K) void'(m_win.pop_front());
      if (m_win.size() == K) begin
        sum = 0;
        for (int c = 0; c < K; c++)
          for (int r = 0; r < ROWS; r++)
            sum += longint'(m_win[c][r*DW +: DW]) * longint'(m_coef[r*K + c]);
        a = model_result(sum, 4);
        b = model_result(sum, 0);
        exp_q.push_back({a[OW-1:0], a[OW], b[OW-1:0], b[OW]});
      end
    end
  endtask

  // driver: one clock cycle, inputs applied just after a falling edge
  task automatic cycle(input logic v, input logic [ROWS*DW-1:0] d, input logic fl,
                       input logic ordy, input logic we, input logic [3:0] a,
                       input logic [CW-1:0] cd, output logic acc_o);
    logic [2*OW+1:0] e;
    in_valid = v; in_data = d; flush = fl; out_ready = ordy;
    coef_we = we; coef_addr = a; coef_data = cd;
    #1;
    if (stall_prev) begin
      chk("stall_data_hold", out_data, stall_data);
      chk("stall_valid_hold", out_valid, 1);
    end
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_result observed=%0h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[2*OW+1:OW+2]);
        chk("out_sat", out_sat, e[OW+1]);
        chk("out_valid_s", out_valid_s, 1);
        chk("out_data_s", out_data_s, e[OW:1]);
        chk("out_sat_s", out_sat_s, e[0]);
        delivered++;
      end
    end
    if (we && a < NT) m_coef[a] = cd;
    acc_o = v && in_ready;
    model_step(acc_o, d, fl);
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    @(negedge CLK);
  endtask

  task automatic idle();
    logic acc;
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, '0, acc);
  endtask

  task automatic col(input logic [ROWS*DW-1:0] d, input logic fl);
    logic acc;
    cycle(1'b1, d, fl, 1'b1, 1'b0, 4'd0, '0, acc);
  endtask

  task automatic set_coefs(input logic [CW-1:0] v);
    logic acc;
    for (int i = 0; i < NT; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'(i), v, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin idle(); n++; end
    idle(); idle();
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic acc;
    int base, n;
    logic [ROWS*DW-1:0] d;
    for (int i = 0; i < NT; i++) m_coef[i] = '0;

    #2 RESET = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_valid_s", out_valid_s, 0);
    chk("rst_out_data_s", out_data_s, 0);
    RESET = 1'b0;

    // prime and latency: all coefs 1, columns of 16
    set_coefs(8'd1);
    for (int i = 0; i < 3; i++) col({3{8'd16}}, 1'b0);
    chk("lat_e0", out_valid, 0);
    idle();
    chk("lat_e1", out_valid, 0);
    idle();
    chk("lat_e2_valid", out_valid, 1);
    chk("lat_e2_data", out_data, 16'd9);
    for (int i = 0; i < 4; i++) col({3{8'd16}}, 1'b0);
    drain();

    // signed coefficients
    set_coefs(8'h80);
    idle();
    for (int i = 0; i < 4; i++) col({3{8'd255}}, 1'b0);
    drain();

    // saturation region on the unshifted instance
    set_coefs(8'h7F);
    idle();
    for (int i = 0; i < 4; i++) col({3{8'd255}}, 1'b0);
    drain();

    // backpressure: ten columns after a flush, consumer stalls for five cycles
    for (int i = 0; i < NT; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'(i), 8'($urandom_range(0, 255)), acc);
    base = delivered;
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 4'd0, '0, acc);
    n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      d = 24'($urandom);
      cycle(1'b1, d, 1'b0, !(i >= 4 && i < 9), 1'b0, 4'd0, '0, acc);
      if (acc) n++;
    end
    chk("bp_accepts", n, 10);
    drain();
    chk("bp_count", delivered - base, 8);

    // flush together with the 4th accept
    base = delivered;
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 4'd0, '0, acc);
    for (int i = 0; i < 6; i++) col(24'($urandom), i == 3);
    drain();
    chk("flush_count", delivered - base, 2);

    // coefficient write mid-stream, plus an out-of-range write that must be ignored
    for (int i = 0; i < 6; i++) begin
      if (i == 2) cycle(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b1, 4'd8, 8'd2, acc);
      else if (i == 4) cycle(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b1, 4'd12, 8'd99, acc);
      else col(24'($urandom), 1'b0);
    end
    drain();

    // random stream with coefficient writes, no backpressure
    for (int i = 0; i < 40; i++)
      cycle($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0, 1'b1,
            $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), acc);
    drain();

    // random stream with backpressure and flushes
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, 1'b0, 4'd0, '0, acc);
    drain();

    // reset with tokens in flight
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 4'd0, '0, acc);
    for (int i = 0; i < 5; i++) col(24'($urandom), 1'b0);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid_s", out_valid_s, 0);
    exp_q.delete();
    m_win.delete();
    for (int i = 0; i < NT; i++) m_coef[i] = '0;
    stall_prev = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) idle();
    for (int i = 0; i < 4; i++) col(24'($urandom), 1'b0);
    drain();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
